// File: rtl/rank_filter_3x3.sv
// rank_filter_3x3: 3x3 median/min/max/bypass filter with border replacement, fixed 3-cycle latency
module rank_filter_3x3 #(
    parameter int DATA_W      = 8,
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter bit BORDER_PASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              in_vsync,
    input  logic              in_href,
    input  logic              in_clken,
    input  logic [DATA_W-1:0] p11,
    input  logic [DATA_W-1:0] p12,
    input  logic [DATA_W-1:0] p13,
    input  logic [DATA_W-1:0] p21,
    input  logic [DATA_W-1:0] p22,
    input  logic [DATA_W-1:0] p23,
    input  logic [DATA_W-1:0] p31,
    input  logic [DATA_W-1:0] p32,
    input  logic [DATA_W-1:0] p33,
    output logic [DATA_W-1:0] out_data,
    output logic              out_vsync,
    output logic              out_href,
    output logic              out_clken
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    typedef logic [DATA_W-1:0] pix_t;

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a >= b) ? a : b;
    endfunction
    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a >= b) ? b : a;
    endfunction
    function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
        return max2(max2(a, b), c);
    endfunction
    function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
        return min2(min2(a, b), c);
    endfunction
    function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    logic          vsync_q, href_q, armed;
    logic [1:0]    mode_q, mode_eff;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic          vs_rise, href_fall, border;
    pix_t          win [9];

    assign vs_rise   = in_vsync & ~vsync_q;
    assign href_fall = ~in_href & href_q;
    assign mode_eff  = vs_rise ? mode : mode_q;
    assign border    = in_clken & in_href & (col_cnt == '0 | col_cnt == CW'(IMG_W - 1) |
                                             row_cnt == '0 | row_cnt == RW'(IMG_H - 1));
    assign win = '{p11, p12, p13, p21, p22, p23, p31, p32, p33};

    // Counters only run once a frame start has been seen since reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            armed   <= 1'b0;
            mode_q  <= 2'b00;
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            vsync_q <= in_vsync;
            href_q  <= in_href;
            if (vs_rise) begin
                armed   <= 1'b1;
                mode_q  <= mode;
                col_cnt <= '0;
                row_cnt <= '0;
            end else if (armed) begin
                if (href_fall) begin
                    col_cnt <= '0;
                    if (row_cnt != RW'(IMG_H - 1)) row_cnt <= row_cnt + RW'(1);
                end else if (in_href & in_clken & (col_cnt != CW'(IMG_W - 1))) begin
                    col_cnt <= col_cnt + CW'(1);
                end
            end
        end
    end

    pix_t       s1_hi [3], s1_md [3], s1_lo [3];
    pix_t       s1_c, s2_c, s2_x, s2_y, s2_z, s2_v;
    logic       s1_b, s2_b;
    logic [1:0] s1_m, s2_m;
    logic [2:0] sync_d [3];

    assign s2_v = (s1_m == 2'b01) ? min3(s1_lo[0], s1_lo[1], s1_lo[2]) :
                  (s1_m == 2'b10) ? max3(s1_hi[0], s1_hi[1], s1_hi[2]) : s1_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                s1_hi[r]  <= '0;
                s1_md[r]  <= '0;
                s1_lo[r]  <= '0;
                sync_d[r] <= '0;
            end
            s1_c     <= '0;
            s1_b     <= 1'b0;
            s1_m     <= 2'b00;
            s2_c     <= '0;
            s2_x     <= '0;
            s2_y     <= '0;
            s2_z     <= '0;
            s2_b     <= 1'b0;
            s2_m     <= 2'b00;
            out_data <= '0;
        end else begin
            for (int r = 0; r < 3; r++) begin
                s1_hi[r] <= max3(win[3*r], win[3*r+1], win[3*r+2]);
                s1_md[r] <= med3(win[3*r], win[3*r+1], win[3*r+2]);
                s1_lo[r] <= min3(win[3*r], win[3*r+1], win[3*r+2]);
            end
            s1_c      <= p22;
            s1_b      <= border;
            s1_m      <= mode_eff;
            sync_d[0] <= {in_vsync, in_href, in_clken};
            sync_d[1] <= sync_d[0];
            sync_d[2] <= sync_d[1];
            // Median keeps the min-of-max / med-of-mid / max-of-min triple; others settle in s2_x
            s2_x     <= (s1_m == 2'b00) ? min3(s1_hi[0], s1_hi[1], s1_hi[2]) : s2_v;
            s2_y     <= med3(s1_md[0], s1_md[1], s1_md[2]);
            s2_z     <= max3(s1_lo[0], s1_lo[1], s1_lo[2]);
            s2_c     <= s1_c;
            s2_b     <= s1_b;
            s2_m     <= s1_m;
            out_data <= s2_b ? (BORDER_PASS ? s2_c : '0) :
                        (s2_m == 2'b00) ? med3(s2_x, s2_y, s2_z) : s2_x;
        end
    end

    assign {out_vsync, out_href, out_clken} = sync_d[2];
endmodule

// File: tb/tb_rank_filter_3x3.sv
// tb_rank_filter_3x3: random and directed frames against a sort-by-rank reference model
module tb_rank_filter_3x3;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;

    typedef struct packed {
        logic [7:0] d1, d0;
        logic       vs, hr, ck, dv;
        logic [7:0] dd1, dd0;
    } ent_t;

    logic       clk, rst_n, in_vsync, in_href, in_clken;
    logic [1:0] mode;
    logic [7:0] win [9];
    logic [7:0] out1, out0;
    logic       ovs1, ohr1, ock1, ovs0, ohr0, ock0;

    int         checks, errors;
    ent_t       hist [3];
    logic       m_vs, m_hr, m_armed;
    logic [1:0] m_mode;
    int         m_row, m_col;

    rank_filter_3x3 #(.DATA_W(8), .IMG_W(IMG_W), .IMG_H(IMG_H), .BORDER_PASS(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_vsync(in_vsync), .in_href(in_href),
        .in_clken(in_clken), .p11(win[0]), .p12(win[1]), .p13(win[2]), .p21(win[3]),
        .p22(win[4]), .p23(win[5]), .p31(win[6]), .p32(win[7]), .p33(win[8]),
        .out_data(out1), .out_vsync(ovs1), .out_href(ohr1), .out_clken(ock1));

    rank_filter_3x3 #(.DATA_W(8), .IMG_W(IMG_W), .IMG_H(IMG_H), .BORDER_PASS(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_vsync(in_vsync), .in_href(in_href),
        .in_clken(in_clken), .p11(win[0]), .p12(win[1]), .p13(win[2]), .p21(win[3]),
        .p22(win[4]), .p23(win[5]), .p31(win[6]), .p32(win[7]), .p33(win[8]),
        .out_data(out0), .out_vsync(ovs0), .out_href(ohr0), .out_clken(ock0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // k-th smallest of the window (0 = min, 4 = median, 8 = max)
    function automatic logic [7:0] rank(input int k);
        int lt, le;
        for (int i = 0; i < 9; i++) begin
            lt = 0;
            le = 0;
            for (int j = 0; j < 9; j++) begin
                if (win[j] < win[i]) lt++;
                if (win[j] <= win[i]) le++;
            end
            if (lt <= k && k < le) return win[i];
        end
        return 8'd0;
    endfunction

    function automatic logic [7:0] dir_int(input int kind, input logic [1:0] md);
        case (kind)
            1:       return md == 2'd0 ? 8'd5 : md == 2'd1 ? 8'd1 : md == 2'd2 ? 8'd9 : 8'd3;
            2:       return md >= 2'd2 ? 8'd200 : 8'd0;
            3:       return 8'hFF;
            default: return md == 2'd2 ? 8'hFF : 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] dir_ctr(input int kind);
        return kind == 1 ? 8'd3 : kind == 2 ? 8'd200 : kind == 3 ? 8'hFF : 8'd0;
    endfunction

    task automatic gen_win(input int kind);
        int pos;
        for (int i = 0; i < 9; i++) win[i] = kind == 0 ? 8'($urandom) : kind == 3 ? 8'hFF : 8'd0;
        if (kind == 1) win = '{8'd9, 8'd1, 8'd5, 8'd7, 8'd3, 8'd8, 8'd2, 8'd6, 8'd4};
        if (kind == 2) win[4] = 8'd200;
        if (kind == 4) begin
            pos = $urandom_range(0, 7);
            if (pos >= 4) pos++;
            win[pos] = 8'hFF;
        end
    endtask

    task automatic tick(input logic dv, input logic [7:0] dd1, input logic [7:0] dd0);
        ent_t       e;
        logic       vr, hf, bd;
        logic [1:0] md;
        logic [7:0] v;
        e = '0;
        if (rst_n) begin
            vr = in_vsync && !m_vs;
            hf = !in_href && m_hr;
            md = vr ? mode : m_mode;
            bd = in_clken && in_href &&
                 (m_col == 0 || m_col == IMG_W - 1 || m_row == 0 || m_row == IMG_H - 1);
            v = md == 2'd0 ? rank(4) : md == 2'd1 ? rank(0) : md == 2'd2 ? rank(8) : win[4];
            e.d1 = bd ? win[4] : v;
            e.d0 = bd ? 8'd0 : v;
            e.vs = in_vsync;
            e.hr = in_href;
            e.ck = in_clken;
            e.dv = dv;
            e.dd1 = dd1;
            e.dd0 = dd0;
            if (vr) begin
                m_mode = mode;
                m_armed = 1'b1;
                m_row = 0;
                m_col = 0;
            end else if (m_armed) begin
                if (hf) begin
                    m_col = 0;
                    if (m_row < IMG_H - 1) m_row++;
                end else if (in_clken && in_href && m_col < IMG_W - 1) m_col++;
            end
            m_vs = in_vsync;
            m_hr = in_href;
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = e;
        @(posedge clk);
        #1;
        check("data_bp1", out1, hist[2].d1);
        check("data_bp0", out0, hist[2].d0);
        check("sync_bp1", {ovs1, ohr1, ock1}, {hist[2].vs, hist[2].hr, hist[2].ck});
        check("sync_bp0", {ovs0, ohr0, ock0}, {hist[2].vs, hist[2].hr, hist[2].ck});
        if (hist[2].dv) begin
            check("directed_bp1", out1, hist[2].dd1);
            check("directed_bp0", out0, hist[2].dd0);
        end
    endtask

    task automatic hold_reset(input int n);
        rst_n = 1'b0;
        #1;
        check("reset_data_bp1", out1, 0);
        check("reset_data_bp0", out0, 0);
        check("reset_sync", {ovs1, ohr1, ock1, ovs0, ohr0, ock0}, 0);
        m_vs = 1'b0;
        m_hr = 1'b0;
        m_armed = 1'b0;
        m_mode = 2'd0;
        m_row = 0;
        m_col = 0;
        for (int i = 0; i < 3; i++) hist[i] = '0;
        for (int i = 0; i < n; i++) tick(1'b0, 8'd0, 8'd0);
        rst_n = 1'b1;
    endtask

    task automatic run_frame(input logic [1:0] md, input int kind, input logic [1:0] md_mid,
                             input int rst_row, input bit long_line, input bit gaps, input bit tight);
        bit         after_rst, bord;
        int         c, len;
        logic [7:0] di;
        after_rst = 1'b0;
        mode = md;
        in_href = 1'b0;
        in_clken = 1'b0;
        in_vsync = 1'b1;
        for (int i = 0; i < 2; i++) begin
            gen_win(0);
            tick(1'b0, 8'd0, 8'd0);
        end
        in_vsync = 1'b0;
        for (int i = 0; i < 2; i++) tick(1'b0, 8'd0, 8'd0);
        for (int r = 0; r < IMG_H; r++) begin
            if (r == 2) mode = md_mid;
            len = IMG_W + (long_line ? 2 : 0);
            c = 0;
            while (c < len) begin
                in_href = 1'b1;
                if (gaps && $urandom_range(0, 3) == 0) begin
                    in_clken = 1'b0;
                    gen_win(0);
                    tick(1'b0, 8'd0, 8'd0);
                    continue;
                end
                if (r == rst_row && c == 4 && !after_rst) begin
                    hold_reset(2);
                    after_rst = 1'b1;
                end
                in_clken = 1'b1;
                gen_win(kind);
                bord = r == 0 || r == IMG_H - 1 || c == 0 || c >= IMG_W - 1;
                di = dir_int(kind, md);
                tick(kind != 0 && !after_rst, bord ? dir_ctr(kind) : di, bord ? 8'd0 : di);
                c++;
            end
            in_href = 1'b0;
            in_clken = 1'b0;
            if (!(tight && r == IMG_H - 1))
                for (int i = 0; i < 2; i++) tick(1'b0, 8'd0, 8'd0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        mode = 2'd0;
        in_vsync = 1'b0;
        in_href = 1'b0;
        in_clken = 1'b0;
        for (int i = 0; i < 9; i++) win[i] = 8'd0;
        @(posedge clk);
        #1;
        hold_reset(2);
        run_frame(2'd0, 1, 2'd0, -1, 1'b0, 1'b0, 1'b0);
        run_frame(2'd1, 1, 2'd3, -1, 1'b0, 1'b0, 1'b0);
        run_frame(2'd2, 1, 2'd2, -1, 1'b0, 1'b0, 1'b0);
        run_frame(2'd3, 0, 2'd3, -1, 1'b0, 1'b1, 1'b0);
        for (int m = 0; m < 4; m++) run_frame(2'(m), 2, 2'(m), -1, 1'b0, 1'b0, 1'b0);
        run_frame(2'd0, 3, 2'd0, -1, 1'b0, 1'b0, 1'b0);
        for (int m = 0; m < 3; m++) run_frame(2'(m), 4, 2'(m), -1, 1'b0, 1'b1, 1'b0);
        run_frame(2'd0, 1, 2'd0, -1, 1'b0, 1'b0, 1'b1);
        run_frame(2'd1, 1, 2'd1, -1, 1'b0, 1'b0, 1'b0);
        run_frame(2'd2, 1, 2'd2, -1, 1'b1, 1'b1, 1'b0);
        run_frame(2'd1, 1, 2'd1, 3, 1'b0, 1'b0, 1'b0);
        run_frame(2'd0, 1, 2'd0, -1, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 6; f++)
            run_frame(2'($urandom_range(0, 3)), 0, 2'($urandom_range(0, 3)), -1,
                      1'($urandom_range(0, 1)), 1'b1, f < 5 && $urandom_range(0, 1) == 1);
        for (int i = 0; i < 4; i++) tick(1'b0, 8'd0, 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
